// File: rtl/vga_pkg.sv
// Shared VGA timing constants, sprite types and slot record for the sprite compositor.
package vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int H_TOTAL      = 800;
  localparam int V_ACTIVE     = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;
  localparam int V_TOTAL      = 525;

  // Widest sprite type a slot can hold; the top uses the low TYPE_W bits.
  localparam int MAX_TYPE_W = 8;

  typedef enum logic [1:0] {
    FROG     = 2'd0,
    BLUE_CAR = 2'd1,
    RED_CAR  = 2'd2,
    HEART    = 2'd3
  } sprite_t;

  typedef logic [8:0] rgb9_t;

  typedef struct packed {
    logic [4:0]            col;
    logic [3:0]            row;
    logic [MAX_TYPE_W-1:0] typ;
    logic                  vis;
  } slot_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel/line counters, raw active-low syncs, active-area flag and frame_start pulse.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACT = H_ACTIVE,
  parameter int H_SS  = H_SYNC_START,
  parameter int H_SE  = H_SYNC_END,
  parameter int H_TOT = H_TOTAL,
  parameter int V_ACT = V_ACTIVE,
  parameter int V_SS  = V_SYNC_START,
  parameter int V_SE  = V_SYNC_END,
  parameter int V_TOT = V_TOTAL
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hs,
  output logic       vs,
  output logic       active,
  output logic       frame_start
);

  logic line_end;
  assign line_end = (h == 10'(H_TOT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      h           <= '0;
      v           <= '0;
      frame_start <= 1'b0;
    end else begin
      // Registered so it lands exactly on the cycle the counters read (0, V_ACT).
      frame_start <= line_end && (v == 10'(V_ACT - 1));
      if (line_end) begin
        h <= '0;
        v <= (v == 10'(V_TOT - 1)) ? '0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  assign hs     = !((h >= 10'(H_SS)) && (h < 10'(H_SE)));
  assign vs     = !((v >= 10'(V_SS)) && (v < 10'(V_SE)));
  assign active = (h < 10'(H_ACT)) && (v < 10'(V_ACT));

endmodule

// File: rtl/vga_sprite_compositor.sv
// Grid sprite compositor: double-buffered slot banks, priority hit, 3-stage pixel pipeline
// with one synchronous sprite ROM port, and per-frame player collision reporting.
module vga_sprite_compositor
  import vga_pkg::*;
#(
  parameter int NUM_SLOTS = 16,
  parameter int CELL_LOG2 = 5,
  parameter int COLS      = 20,
  parameter int ROWS      = 15,
  parameter int TYPE_W    = 2,
  parameter int H_ACT     = H_ACTIVE,
  parameter int H_SS      = H_SYNC_START,
  parameter int H_SE      = H_SYNC_END,
  parameter int H_TOT     = H_TOTAL,
  parameter int V_ACT     = V_ACTIVE,
  parameter int V_SS      = V_SYNC_START,
  parameter int V_SE      = V_SYNC_END,
  parameter int V_TOT     = V_TOTAL
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [$clog2(NUM_SLOTS)-1:0]    wr_slot,
  input  logic [4:0]                      wr_col,
  input  logic [3:0]                      wr_row,
  input  logic [TYPE_W-1:0]               wr_type,
  input  logic                            wr_vis,
  output logic [9:0]                      bg_x,
  output logic [9:0]                      bg_y,
  input  logic [8:0]                      bg_rgb,
  output logic [TYPE_W+2*CELL_LOG2-1:0]   rom_addr,
  input  logic [5:0]                      rom_data,
  output logic [2:0]                      vga_r,
  output logic [2:0]                      vga_g,
  output logic [2:0]                      vga_b,
  output logic                            vga_hs,
  output logic                            vga_vs,
  output logic                            frame_start,
  output logic                            collision
);

  localparam int IDX_W  = $clog2(NUM_SLOTS);
  localparam int STAGES = 3;

  logic [9:0] h, v;
  logic       hs_raw, vs_raw, active;

  vga_timing_gen #(
    .H_ACT(H_ACT), .H_SS(H_SS), .H_SE(H_SE), .H_TOT(H_TOT),
    .V_ACT(V_ACT), .V_SS(V_SS), .V_SE(V_SE), .V_TOT(V_TOT)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .h           (h),
    .v           (v),
    .hs          (hs_raw),
    .vs          (vs_raw),
    .active      (active),
    .frame_start (frame_start)
  );

  assign bg_x = h;
  assign bg_y = v;

  slot_t pend [NUM_SLOTS];
  slot_t act  [NUM_SLOTS];

  // Copy reads pend before this edge's write, so a copy-cycle write waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pend[i] <= '0;
        act[i]  <= '0;
      end
    end else begin
      if (frame_start) act <= pend;
      if (wr_en && (int'(wr_slot) < NUM_SLOTS))
        pend[wr_slot] <= '{col: wr_col, row: wr_row, typ: MAX_TYPE_W'(wr_type), vis: wr_vis};
    end
  end

  logic [NUM_SLOTS-1:0] match;
  logic [NUM_SLOTS-1:0] unused_typ;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign match[i] = active && act[i].vis
                   && (int'(act[i].col) < COLS) && (int'(act[i].row) < ROWS)
                   && (int'(act[i].col) == int'(h >> CELL_LOG2))
                   && (int'(act[i].row) == int'(v >> CELL_LOG2));
    assign unused_typ[i] = ^act[i].typ;
  end

  logic [IDX_W-1:0] win;
  always_comb begin
    win = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (match[i]) win = IDX_W'(i);
  end

  logic coll_now;
  assign coll_now = match[0] && (|match[NUM_SLOTS-1:1]);

  logic                   hit1, hit2;
  logic [TYPE_W-1:0]      typ1;
  logic [CELL_LOG2-1:0]   sx1, sy1;
  rgb9_t                  bg1, bg2, rgb3;
  logic [STAGES-1:1]      vld_pipe;
  logic [STAGES:1]        hs_pipe, vs_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      hit1     <= 1'b0;
      hit2     <= 1'b0;
      typ1     <= '0;
      sx1      <= '0;
      sy1      <= '0;
      bg1      <= '0;
      bg2      <= '0;
      rgb3     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:1], active};
      hs_pipe  <= {hs_pipe[STAGES-1:1], hs_raw};
      vs_pipe  <= {vs_pipe[STAGES-1:1], vs_raw};
      hit1     <= |match;
      typ1     <= act[win].typ[TYPE_W-1:0];
      sx1      <= h[CELL_LOG2-1:0];
      sy1      <= v[CELL_LOG2-1:0];
      bg1      <= bg_rgb;
      hit2     <= hit1;
      bg2      <= bg1;
      // rom_data answers the stage-1 address, so it lines up with stage 2 here.
      if (!vld_pipe[2])
        rgb3 <= '0;
      else if (hit2 && (rom_data != 6'd0))
        rgb3 <= {rom_data[5:4], 1'b0, rom_data[3:2], 1'b0, rom_data[1:0], 1'b0};
      else
        rgb3 <= bg2;
    end
  end

  assign rom_addr = {typ1, sy1, sx1};
  assign vga_r    = rgb3[8:6];
  assign vga_g    = rgb3[5:3];
  assign vga_b    = rgb3[2:0];
  assign vga_hs   = hs_pipe[STAGES];
  assign vga_vs   = vs_pipe[STAGES];

  logic sticky;
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky    <= 1'b0;
      collision <= 1'b0;
    end else if (frame_start) begin
      collision <= sticky;
      sticky    <= 1'b0;
    end else if (coll_now) begin
      sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Scoreboard bench: a frame-level model predicts every pin per cycle; a monitor compares.
module tb_vga_sprite_compositor;
  import vga_pkg::*;

  localparam int NS = 12, CL = 3, COLS = 20, ROWS = 15, TW = 2;
  localparam int HA = 80, HSS = 84, HSE = 92, HT = 100;
  localparam int VA = 48, VSS = 50, VSE = 52, VT = 54;
  localparam int CELL = 1 << CL;
  localparam int AW = TW + 2 * CL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_slot = '0;
  logic [4:0]    wr_col = '0;
  logic [3:0]    wr_row = '0;
  logic [TW-1:0] wr_type = '0;
  logic          wr_vis = 1'b0;
  logic [9:0]    bg_x, bg_y;
  logic [8:0]    bg_rgb;
  logic [AW-1:0] rom_addr;
  logic [5:0]    rom_data = '0;
  logic [2:0]    vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs, frame_start, collision;

  vga_sprite_compositor #(
    .NUM_SLOTS(NS), .CELL_LOG2(CL), .COLS(COLS), .ROWS(ROWS), .TYPE_W(TW),
    .H_ACT(HA), .H_SS(HSS), .H_SE(HSE), .H_TOT(HT),
    .V_ACT(VA), .V_SS(VSS), .V_SE(VSE), .V_TOT(VT)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_slot(wr_slot), .wr_col(wr_col),
    .wr_row(wr_row), .wr_type(wr_type), .wr_vis(wr_vis), .bg_x(bg_x), .bg_y(bg_y),
    .bg_rgb(bg_rgb), .rom_addr(rom_addr), .rom_data(rom_data), .vga_r(vga_r),
    .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .frame_start(frame_start), .collision(collision)
  );

  always #20 clk = ~clk;

  function automatic logic [8:0] bg_fn(int x, int y);
    return 9'((x * 7) ^ (y * 13) ^ 165);
  endfunction
  assign bg_rgb = bg_fn(int'(bg_x), int'(bg_y));

  logic [5:0] rom_tab [1 << AW];
  always @(posedge clk) rom_data <= rom_tab[rom_addr];

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  typedef struct { int col; int row; int typ; bit vis; } mslot_t;
  typedef struct { int due; int kind; int exp; } chk_t;

  mslot_t pend_m [NS];
  mslot_t act_m  [NS];
  chk_t   sb[$];
  int     mh = 0, mv = 0, cyc = 0;
  bit     coll = 0, sticky = 0;
  string  nm [8] = '{"frame_start", "collision", "bg_x", "bg_y", "rom_addr", "rgb", "vga_hs", "vga_vs"};

  function automatic void push(int due, int kind, int exp);
    chk_t c;
    c.due = due; c.kind = kind; c.exp = exp;
    sb.push_back(c);
  endfunction

  function automatic bit pcoll(int x, int y);
    if (!(x < HA && y < VA) || !act_m[0].vis) return 1'b0;
    if (act_m[0].col != x / CELL || act_m[0].row != y / CELL) return 1'b0;
    for (int j = 1; j < NS; j++)
      if (act_m[j].vis && act_m[j].col == act_m[0].col && act_m[j].row == act_m[0].row) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void push_pixel(int n);
    int x, y, win, addr, d, rgb;
    bit on;
    x = mh; y = mv; win = -1; addr = 0;
    on = (x < HA) && (y < VA);
    push(n, 0, int'(x == 0 && y == VA));
    push(n, 1, int'(coll));
    push(n, 2, x);
    push(n, 3, y);
    if (on)
      for (int i = 0; i < NS; i++)
        if (win < 0 && act_m[i].vis && act_m[i].col < COLS && act_m[i].row < ROWS &&
            act_m[i].col == x / CELL && act_m[i].row == y / CELL) win = i;
    if (win >= 0) begin
      addr = act_m[win].typ * CELL * CELL + (y % CELL) * CELL + (x % CELL);
      push(n + 1, 4, addr);
    end
    if (!on) rgb = 0;
    else if (win >= 0 && rom_tab[addr] != 6'd0) begin
      d   = int'(rom_tab[addr]);
      rgb = ((d >> 4) & 3) * 2 * 64 + ((d >> 2) & 3) * 2 * 8 + (d & 3) * 2;
    end else rgb = int'(bg_fn(x, y));
    push(n + 3, 5, rgb);
    push(n + 3, 6, int'(!(x >= HSS && x < HSE)));
    push(n + 3, 7, int'(!(y >= VSS && y < VSE)));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mh = 0; mv = 0; coll = 0; sticky = 0;
      for (int i = 0; i < NS; i++) begin
        pend_m[i] = '{0, 0, 0, 1'b0};
        act_m[i]  = '{0, 0, 0, 1'b0};
      end
      sb.delete();
      cyc++;
      for (int k = 0; k < 3; k++) begin
        push(cyc + k, 5, 0); push(cyc + k, 6, 1); push(cyc + k, 7, 1);
      end
      push_pixel(cyc);
    end else begin
      if (mh == 0 && mv == VA) begin
        coll = sticky; sticky = 0; act_m = pend_m;
      end else if (pcoll(mh, mv)) sticky = 1;
      if (wr_en && int'(wr_slot) < NS)
        pend_m[wr_slot] = '{int'(wr_col), int'(wr_row), int'(wr_type), wr_vis};
      if (mh == HT - 1) begin
        mh = 0; mv = (mv == VT - 1) ? 0 : mv + 1;
      end else mh = mh + 1;
      cyc++;
      push_pixel(cyc);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int i;
    logic [31:0] a, e;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].kind)
          0: a = 32'(frame_start);
          1: a = 32'(collision);
          2: a = 32'(bg_x);
          3: a = 32'(bg_y);
          4: a = 32'(rom_addr);
          5: a = 32'({vga_r, vga_g, vga_b});
          6: a = 32'(vga_hs);
          default: a = 32'(vga_vs);
        endcase
        e = sb[i].exp;
        checks++;
        if (sb[i].due != cyc || a !== e) begin
          errors++;
          if (errors < 40)
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm[sb[i].kind], cyc, a, e);
        end
        sb.delete(i);
      end else i++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr_now(input int s, input int c, input int r, input int t, input bit vis);
    wr_en = 1'b1; wr_slot = 4'(s); wr_col = 5'(c); wr_row = 4'(r); wr_type = TW'(t); wr_vis = vis;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wr(input int s, input int c, input int r, input int t, input bit vis);
    @(negedge clk);
    wr_now(s, c, r, t, vis);
  endtask

  task automatic wait_fs();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 6000 && !seen; n++) begin
      @(negedge clk);
      if (frame_start === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_frame_start timeout got=0 want=1");
    end
  endtask

  initial begin
    int k;
    for (int a = 0; a < (1 << AW); a++)
      rom_tab[a] = (a < CELL * CELL || $urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
    rom_tab[int'(BLUE_CAR) * CELL * CELL] = 6'b110000;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // first hs fall should reach the pin H_SYNC_START+3 cycles after release
    k = 0;
    while (k < 2000) begin
      @(posedge clk); k++; #1;
      if (vga_hs === 1'b0) break;
    end
    checks++;
    if (k != HSS + 3) begin
      errors++;
      $display("FAIL hs_first_fall got=%0d want=%0d", k, HSS + 3);
    end

    wr(3, 2, 1, int'(BLUE_CAR), 1'b1);
    wr(0, 4, 4, int'(FROG), 1'b1);
    wr(5, 4, 4, int'(RED_CAR), 1'b1);
    wr(9, 4, 4, int'(HEART), 1'b1);
    wr(1, 3, 2, int'(BLUE_CAR), 1'b1);
    wr(6, 25, 4, int'(RED_CAR), 1'b1);
    wr(4, 25, 0, int'(HEART), 1'b1);
    wr(14, 1, 1, int'(HEART), 1'b1);
    wait_fs();

    repeat (1500) @(negedge clk);
    wr(1, 7, 2, int'(BLUE_CAR), 1'b1);
    wr(9, 8, 5, int'(HEART), 1'b1);
    wr(5, 0, 5, int'(RED_CAR), 1'b1);
    wait_fs();
    wr_now(2, 6, 3, int'(RED_CAR), 1'b1);

    repeat (1000) @(negedge clk);
    wr(0, 25, 4, int'(FROG), 1'b1);
    wait_fs();
    wait_fs();

    for (int f = 0; f < 4; f++) begin
      for (int w = 0; w < 8; w++) begin
        repeat ($urandom_range(20, 600)) @(negedge clk);
        wr($urandom_range(0, 15), $urandom_range(0, 11), $urandom_range(0, 7),
           $urandom_range(0, 3), $urandom_range(0, 3) != 0);
      end
      wait_fs();
      if (f == 1) wr_now(0, $urandom_range(0, 9), $urandom_range(0, 5), int'(BLUE_CAR), 1'b1);
    end

    repeat (700) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
